mux_n_reg: RTL and testbench
============================

Name: mux_n_reg

Overview:
Parametrised N:1, W-bit multiplexer with a registered output stage and a valid/ready handshake on every channel and on the output. It replaces the single-bit combinational 2:1 select used in the ALU/register datapath. It adds a held select register and an optional round-robin arbitration mode. It sits between the register-file read channels and the ALU operand inputs.

Parameters:
N, 4, number of input channels; must be at least 2.
W, 8, data width per channel.
SW, $clog2(N), select width; derived, not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel valid
in_ready  output  N  per-channel ready; combinational
sel_in  input  SW  new fixed-mode select value
sel_load  input  1  when high, sel_in is written to the select register
mode  input  1  0 = fixed select, 1 = round-robin (only when MUX_RR_EN is defined)
out_data  output  W  registered data
out_valid  output  1  registered valid
out_chan  output  SW  registered index of the channel that supplied out_data
out_ready  input  1  downstream ready

Behaviour:
- Reset (asynchronous, rst_n low): out_data=0, out_valid=0, out_chan=0, sel_q=0, rr_ptr=0.
- Reset mid-transfer drops the held word. Nothing is replayed after reset.
- can_accept = !out_valid | out_ready. This allows full throughput of one word per cycle with no bubble.
- Fixed mode: grant = sel_q.
  - in_ready[sel_q] = can_accept; all other in_ready bits = 0.
  - A transfer happens when in_valid[sel_q] & can_accept.
- Round-robin mode: grant = the first index with in_valid set, searching from rr_ptr upward and wrapping N-1 -> 0.
  - in_ready[grant] = can_accept; all other bits = 0.
  - If no channel is valid, no in_ready bit is asserted.
- On a transfer: out_data <= in_data[grant], out_chan <= grant, out_valid <= 1. Latency is 1 cycle from input handshake to out_valid.
- After an RR transfer, rr_ptr <= grant+1, wrapping N-1 -> 0.
- If out_ready is high and there is no transfer, out_valid <= 0 and out_data/out_chan hold their values.
- If out_valid is high and out_ready is low, the output registers are stable. Stall is lossless.
- sel_load: sel_q <= sel_in at the next edge.
  - A transfer in the same cycle uses the old sel_q.
  - If sel_in >= N (N not a power of 2), the load is ignored and sel_q holds.
- mode is sampled combinationally every cycle and may change at any time. rr_ptr is kept across mode changes.
- Fixed-mode select changes never corrupt a word already held in the output register.
- in_ready never depends on in_valid in fixed mode. In RR mode it depends only on the grant search.

Optional Feature:
MUX_RR_EN
- Defined: round-robin mode and the rr_ptr register are built. mode=1 selects RR.
- Undefined: mode is ignored and the block is always in fixed select. rr_ptr logic is removed; the mode port remains but has no loads.

Decomposition:
- Package mux_pkg holds:
  - a clog2-safe select-width function;
  - mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1;
  - the reset value constant for out_data.
- One sub-module, rr_pick, is natural. It is purely combinational: N valid bits + pointer in, one grant index + any-valid flag out.
- The output register stage stays in mux_n_reg.

Test Plan:
- Reset check: rst_n asserted mid-stall with out_valid=1 -> out_valid=0, out_data=0, out_chan=0, sel_q=0 immediately (asynchronous).
- Fixed select: N=4, W=8. sel_load with sel_in=2; ch2=8'hA5 valid, out_ready=1 -> next cycle out_data=A5, out_chan=2; in_ready=4'b0100 throughout.
- Backpressure: out_ready=0 for 3 cycles with ch2 streaming 01,02,03 -> out_data holds 01 and in_ready[2]=0. On release, 02 and 03 emerge on consecutive cycles with no loss or duplication.
- Select change in flight: sel_load(sel_in=1) in the same cycle as a ch2 transfer -> that word reports out_chan=2. The next word comes from ch1.
- Round-robin (MUX_RR_EN): all 4 channels continuously valid, out_ready=1 -> out_chan sequence 0,1,2,3,0. With only ch1 and ch3 valid -> 1,3,1,3.
- Illegal select: N=3. sel_load with sel_in=3 -> sel_q unchanged. With MUX_RR_EN undefined, mode=1 -> behaviour identical to fixed mode.

Source files
------------

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the registered N:1 multiplexer (mux_n_reg) and its
// round-robin picker (rr_pick).
//   sel_width()    : select width that stays at least 1 bit wide
//   MODE_FIXED/RR  : encodings of the mode input
//   OUT_DATA_RST   : per-bit reset value of the output data register
// Optional feature macro used by the users of this package: MUX_RR_EN
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED   = 1'b0;
    localparam logic MODE_RR      = 1'b1;

    // Replicated to the data width at the point of use.
    localparam logic OUT_DATA_RST = 1'b0;

    // $clog2(1) is 0, which would give a zero-width select; clamp to 1 bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_n_reg_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin grant search. Starting at ptr and moving
// upward (wrapping N-1 -> 0), returns the first index whose valid bit is set.
// Ports:
//   valid     in  N   per-channel valid bits
//   ptr       in  SW  search start index (always < N)
//   grant     out SW  selected channel index (0 when nothing is valid)
//   any_valid out 1   at least one valid bit set
// ---------------------------------------------------------------------------
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          any_valid
);

    // Walk the offsets from farthest to nearest so the last hit, i.e. the
    // one closest to ptr, is the value left in grant.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (valid[idx]) begin
                grant     = SW'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// ---------------------------------------------------------------------------
// mux_n_reg
// N:1, W-bit multiplexer with a registered output stage and valid/ready
// handshakes on every input channel and on the output. The select comes from
// a held register (sel_q) loaded through sel_in/sel_load; with MUX_RR_EN
// defined, mode=1 switches to round-robin arbitration among valid channels.
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_data[N*W]        channel i at bits [i*W +: W]
//   in_valid[N]         per-channel valid
//   in_ready[N]         per-channel ready (combinational)
//   sel_in, sel_load    fixed-mode select value and its load strobe
//   mode                0 fixed, 1 round-robin (only with MUX_RR_EN)
//   out_data/out_valid/out_chan  registered output word, valid, source index
//   out_ready           downstream ready
// Optional feature macro: MUX_RR_EN (round-robin mode and rr_ptr register).
// ---------------------------------------------------------------------------
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = sel_width(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel_in,
    input  logic            sel_load,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic [SW-1:0]   out_chan,
    input  logic            out_ready
);

    logic [SW-1:0] sel_q, sel_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] out_chan_q, out_chan_d;

    logic          can_accept;
    logic [SW-1:0] grant;
    logic          grant_vld;
    logic          ready_en;
    logic          xfer;

    // The output register may take a new word whenever it is empty or its
    // current word is leaving this cycle, so streaming needs no bubble.
    assign can_accept = !out_valid_q || out_ready;

`ifdef MUX_RR_EN
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] rr_grant;
    logic          rr_any;
    logic          rr_mode;

    assign rr_mode = (mode == MODE_RR);

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .valid     (in_valid),
        .ptr       (rr_ptr_q),
        .grant     (rr_grant),
        .any_valid (rr_any)
    );
`else
    // mode has no loads in the fixed-only build.
    logic unused_mode;
    assign unused_mode = mode;
`endif

    always_comb begin
        grant     = sel_q;
        grant_vld = in_valid[sel_q];
        // Fixed mode offers ready regardless of in_valid.
        ready_en  = 1'b1;
`ifdef MUX_RR_EN
        if (rr_mode) begin
            grant     = rr_grant;
            grant_vld = rr_any;
            ready_en  = rr_any;
        end
`endif
    end

    assign xfer = grant_vld && can_accept;

    always_comb begin
        in_ready        = '0;
        in_ready[grant] = can_accept && ready_en;
    end

    always_comb begin
        sel_d = sel_q;
        // Out-of-range selects (N not a power of two) are dropped.
        if (sel_load && (int'(sel_in) < N)) begin
            sel_d = sel_in;
        end
    end

`ifdef MUX_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rr_mode && xfer) begin
            rr_ptr_d = (int'(grant) == N - 1) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        if (xfer) begin
            out_data_d  = in_data[grant*W +: W];
            out_chan_d  = grant;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            // Word consumed with nothing behind it; data/chan keep last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            out_data_q  <= {W{OUT_DATA_RST}};
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
        end else begin
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_n_reg.sv
module tb_mux_n_reg;

    logic        clk;
    logic        rst_n;

    // N=4, W=8 instance
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [1:0]  sel_in;
    logic        sel_load;
    logic        mode;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [1:0]  out_chan;
    logic        out_ready;

    // N=3, W=8 instance (non power of two select range)
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [1:0]  sel_in3;
    logic        sel_load3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic [1:0]  out_chan3;
    logic        out_ready3;

    int checks;
    int errors;

    mux_n_reg #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    mux_n_reg #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .sel_in    (sel_in3),
        .sel_load  (sel_load3),
        .mode      (1'b0),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_chan  (out_chan3),
        .out_ready (out_ready3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_chan);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_sel: got in_ready=%b want 0001", in_ready);
        end
        // Build a stalled word on ch2, then reset between clock edges.
        sel_in = 2'd2; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        in_data[16 +: 8] = 8'h77; in_valid = 4'b0100; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h77 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL stall_before_reset: got v=%b d=%h c=%0d want v=1 d=77 c=2", out_valid, out_data, out_chan);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h c=%0d want v=0 d=00 c=0", out_valid, out_data, out_chan);
        end
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_sel: got in_ready=%b want 0001", in_ready);
        end
        #1 rst_n = 1'b1;
        in_valid = 4'b0000; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_replay: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fixed();
        sel_in = 2'd2; sel_load = 1'b1; in_valid = 4'b0000; out_ready = 1'b1;
        tick();
        sel_load = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready_idle: got %b want 0100", in_ready);
        end
        in_data = 32'h11_A5_33_44; in_valid = 4'b0100;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_ready_valid: got %b want 0100", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL fixed_out: got v=%b d=%h c=%0d want v=1 d=a5 c=2", out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
            errors++;
            $display("FAIL fixed_drain: got v=%b d=%h want v=0 d=a5", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data[16 +: 8] = 8'h01; in_valid = 4'b0100;
        tick();
        in_data[16 +: 8] = 8'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h01 || in_ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b d=%h rdy=%b want v=1 d=01 rdy=0", i, out_valid, out_data, in_ready[2]);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h02) begin
            errors++;
            $display("FAIL release_02: got v=%b d=%h want v=1 d=02", out_valid, out_data);
        end
        in_data[16 +: 8] = 8'h03;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h03) begin
            errors++;
            $display("FAIL release_03: got v=%b d=%h want v=1 d=03", out_valid, out_data);
        end
        in_valid = 4'b0000;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h03) begin
            errors++;
            $display("FAIL release_end: got v=%b d=%h want v=0 d=03", out_valid, out_data);
        end
    endtask

    task automatic test_sel_change();
        out_ready = 1'b1;
        in_data = 32'h00_C2_B1_00; in_valid = 4'b0110;
        sel_in = 2'd1; sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hC2 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL selchg_old: got v=%b d=%h c=%0d want v=1 d=c2 c=2", out_valid, out_data, out_chan);
        end
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL selchg_ready: got %b want 0010", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hB1 || out_chan !== 2'd1) begin
            errors++;
            $display("FAIL selchg_new: got v=%b d=%h c=%0d want v=1 d=b1 c=1", out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000;
        tick();
    endtask

`ifdef MUX_RR_EN
    task automatic test_round_robin();
        logic [1:0] exp_all [5];
        logic [1:0] exp_odd [4];
        exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_odd = '{2'd1, 2'd3, 2'd1, 2'd3};
        mode = 1'b1; out_ready = 1'b1;
        in_data = 32'h13_12_11_10; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== exp_all[i] || out_data !== (8'h10 + 8'(exp_all[i]))) begin
                errors++;
                $display("FAIL rr_all_%0d: got c=%0d d=%h want c=%0d", i, out_chan, out_data, exp_all[i]);
            end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== exp_odd[i]) begin
                errors++;
                $display("FAIL rr_odd_%0d: got v=%b c=%0d want c=%0d", i, out_valid, out_chan, exp_odd[i]);
            end
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rr_idle_ready: got %b want 0000", in_ready);
        end
        mode = 1'b0;
        tick();
    endtask
`else
    task automatic test_mode_ignored();
        // sel_q is 1 from the previous test; mode=1 must still act as fixed.
        mode = 1'b1; out_ready = 1'b1;
        in_valid = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mode_ignored_ready: got %b want 0010", in_ready);
        end
        in_data = 32'h13_12_11_10; in_valid = 4'b1111;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 8'h11) begin
            errors++;
            $display("FAIL mode_ignored_out: got v=%b c=%0d d=%h want v=1 c=1 d=11", out_valid, out_chan, out_data);
        end
        in_valid = 4'b0000; mode = 1'b0;
        tick();
    endtask
`endif

    task automatic test_illegal_sel();
        out_ready3 = 1'b1; in_valid3 = 3'b000;
        sel_in3 = 2'd2; sel_load3 = 1'b1;
        tick();
        checks++;
        if (in_ready3 !== 3'b100) begin
            errors++;
            $display("FAIL n3_legal_load: got %b want 100", in_ready3);
        end
        sel_in3 = 2'd3;
        tick();
        sel_load3 = 1'b0;
        checks++;
        if (in_ready3 !== 3'b100) begin
            errors++;
            $display("FAIL n3_illegal_load: got %b want 100", in_ready3);
        end
        in_data3 = 24'h5A_22_11; in_valid3 = 3'b111;
        tick();
        checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'h5A || out_chan3 !== 2'd2) begin
            errors++;
            $display("FAIL n3_out: got v=%b d=%h c=%0d want v=1 d=5a c=2", out_valid3, out_data3, out_chan3);
        end
        in_valid3 = 3'b000;
        tick();
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        in_data = '0; in_valid = '0; sel_in = '0; sel_load = 1'b0; mode = 1'b0; out_ready = 1'b1;
        in_data3 = '0; in_valid3 = '0; sel_in3 = '0; sel_load3 = 1'b0; out_ready3 = 1'b1;
        test_reset();
        test_fixed();
        test_backpressure();
        test_sel_change();
`ifdef MUX_RR_EN
        test_round_robin();
`else
        test_mode_ignored();
`endif
        test_illegal_sel();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
